bus_master_ctrl: RTL and testbench
==================================

Name: bus_master_ctrl

Overview:
- Initiator side of the sEP8 external memory bus: turns a single-beat CPU-side request into the s_/mr_/mw_ strobe sequence on a23_a0/d7_d0.
- The bus responders (ROM, RAM, I/O) answer combinationally after a read delay.
- Sits between the sEP8 core and the memory devices; one transaction in flight at a time.

Parameters:
- WAIT_CYCLES, 2, extra cycles mr_/mw_ stay asserted beyond the first; legal 0..15 (4-bit counter); must cover responder read delay.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  transaction request, level; sampled only in IDLE
- we  input  1  1 = write, 0 = read; latched with req
- addr  input  24  transaction address; latched with req
- wdata  input  8  write data; latched with req
- rdata  output  8  read data, valid from ack onward, held until next read completes
- ack  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE
- a23_a0  output  24  bus address
- s_  output  1  bus select, active low
- mr_  output  1  memory read strobe, active low
- mw_  output  1  memory write strobe, active low
- d7_d0  inout  8  bus data; driven only during write phases, else Z

Behaviour:
- Reset values: s_=mr_=mw_=1, ack=0, busy=0, rdata=8'h00, a23_a0=24'h000000, d7_d0=Z, counter=0, state=IDLE.
- Reset mid-transaction: at the next edge everything returns to reset values. Transaction is aborted, no ack, d7_d0 released.
- IDLE:
  - Strobes high, d7_d0 Z, a23_a0 holds last address.
  - req=1 at an edge latches addr/we/wdata and moves to SETUP.
- SETUP (1 cycle):
  - a23_a0=latched addr, s_=0, mr_=mw_=1.
  - Write: d7_d0 driven with latched wdata.
  - Counter loaded with WAIT_CYCLES.
  - Goes to READ or WRITE per we.
- READ (WAIT_CYCLES+1 cycles):
  - s_=0, mr_=0, counter decrements each cycle.
  - At the edge ending the cycle where counter==0: rdata<=d7_d0, go HOLD.
- WRITE (WAIT_CYCLES+1 cycles):
  - s_=0, mw_=0, d7_d0=wdata.
  - Exit on counter==0 as in READ.
- HOLD (1 cycle):
  - mr_=mw_=1, s_=0, address held.
  - Write data still driven (hold time).
  - Go to ACK.
- ACK (1 cycle):
  - s_=1, d7_d0 Z, ack=1, busy=1.
  - Go to IDLE unconditionally.
- Latency: req sampled at edge E0 gives ack high during cycle E0+WAIT_CYCLES+4 (SETUP, W+1 strobe cycles, HOLD, ACK).
  - Example: W=2 puts ack in the 6th cycle after E0.
- req is ignored outside IDLE; addr/we/wdata changes after acceptance have no effect.
- Back-to-back: if req is still high in the ACK cycle, the next transaction is accepted at the first IDLE edge.
  - Minimum one IDLE cycle between transactions, giving s_ a high pulse of ≥2 cycles.
  - The requester drops req during ack to avoid a repeat.
- Strobe exclusivity: mr_ and mw_ never low together; strobes low only while s_=0; address stable from SETUP through HOLD.
- W=0: READ/WRITE last exactly 1 cycle.

Optional Feature:
- Macro: BUS_READY_EN
- Defined:
  - Adds input port ready_ (1 bit, active low).
  - In READ/WRITE, once counter==0, the state is held while ready_=1.
  - Sampling/exit happen at the first edge with counter==0 and ready_=0.
  - No timeout; reset is the only escape.
- Undefined:
  - ready_ port absent.
  - Strobe width fixed at WAIT_CYCLES+1.

Test Plan:
- Read, W=2, responder returns 8'h41 at 24'hFF0002 after its delay.
  - req/we=0/addr=FF0002 → a23_a0=FF0002, s_ low 5 cycles, mr_ low 3 cycles, ack in 6th cycle, rdata=8'h41, d7_d0 never driven.
- Write 8'hA5 to 24'h000010, W=2.
  - mw_ low 3 cycles, d7_d0=A5 from SETUP through HOLD, Z in ACK.
  - RAM model holds A5 at 000010; rdata unchanged.
- Back-to-back, req held high across two reads (FF0000 → 8'h00, FF0001 → next byte).
  - Two ack pulses 7 cycles apart, one IDLE cycle between, both rdata values correct.
- Reset asserted in 2nd READ cycle.
  - Next edge: s_=mr_=1, rdata=00, busy=0, no ack; a following read completes normally.
- W=0 read of FF000E.
  - mr_ low exactly 1 cycle, ack 4 cycles after req, rdata matches the responder byte (needs a zero-delay responder).
- BUS_READY_EN, W=0, ready_ held high 3 extra cycles on a read.
  - mr_ low 4 cycles, rdata sampled at the ready_=0 edge, ack 3 cycles later than the fixed-timing case.

Source files
------------

// File: rtl/bus_master_ctrl.sv
// sEP8 external bus initiator: turns one CPU-side request into a select/read/write strobe sequence.
// Optional macro BUS_READY_EN adds an active-low ready_ input that stretches the strobe phase.
module bus_master_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
`ifdef BUS_READY_EN
    input  logic        ready_,
`endif
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic [23:0] a23_a0,
    output logic        s_,
    output logic        mr_,
    output logic        mw_,
    inout  wire  [7:0]  d7_d0
);

    // Handshake: req is a level sampled only in IDLE; the request fields are latched on the
    // accepting edge, and ack is a single-cycle pulse in the cycle after HOLD.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_READ,
        S_WRITE,
        S_HOLD,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic        drive;
    logic        bus_ready;
    logic        strobe_done;

`ifdef BUS_READY_EN
    assign bus_ready = ~ready_;
`else
    assign bus_ready = 1'b1;
`endif

    // The strobe phase ends on the edge closing the cycle where the counter has run out.
    assign strobe_done = (count == 4'd0) && bus_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata   <= 8'h00;
            a23_a0  <= 24'h000000;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        a23_a0  <= addr;
                        we_q    <= we;
                        wdata_q <= wdata;
                    end
                end
                S_SETUP: begin
                    count <= WAIT_LOAD;
                end
                S_READ: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                    if (strobe_done) begin
                        rdata <= d7_d0;
                    end
                end
                S_WRITE: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        s_         = 1'b1;
        mr_        = 1'b1;
        mw_        = 1'b1;
        ack        = 1'b0;
        busy       = 1'b1;
        drive      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                s_         = 1'b0;
                drive      = we_q;
                state_next = we_q ? S_WRITE : S_READ;
            end
            S_READ: begin
                s_  = 1'b0;
                mr_ = 1'b0;
                if (strobe_done) begin
                    state_next = S_HOLD;
                end
            end
            S_WRITE: begin
                s_    = 1'b0;
                mw_   = 1'b0;
                drive = 1'b1;
                if (strobe_done) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                // Write data stays on the bus one cycle past mw_ for responder hold time.
                s_         = 1'b0;
                drive      = we_q;
                state_next = S_ACK;
            end
            S_ACK: begin
                ack        = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign d7_d0 = drive ? wdata_q : 8'hzz;

    a_strobe_excl: assert property (@(posedge clock) disable iff (reset) !(!mr_ && !mw_));
    a_strobe_sel:  assert property (@(posedge clock) disable iff (reset) (!mr_ || !mw_) |-> !s_);
    a_ack_busy:    assert property (@(posedge clock) disable iff (reset) ack |-> busy);

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl: two instances (WAIT_CYCLES 2 and 0), each with its own bus responder,
// reference memory model, expected-transaction queue and monitor.
`timescale 1ns/1ps
module tb_bus_master_ctrl;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
        int          stall;
        int unsigned ack_cyc;
    } txn_t;

    logic        clock = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          lane_done [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder memory: ROM at FF0000..FF000F, RAM at 000010..00001F.
    function automatic int idx(input logic [23:0] a);
        return int'({a[23], a[3:0]});
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 2 : 0;

        logic        rst;
        logic        req;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        ack;
        logic        busy;
        logic [23:0] a23_a0;
        logic        s_;
        logic        mr_;
        logic        mw_;
        wire  [7:0]  d7_d0;
        logic [7:0]  bus_mem [32];
        logic [7:0]  ref_mem [32];
        int          strb_cnt = 0;
        int          stall = 0;
        int unsigned free_edge = 0;
        txn_t        exp_q [$];
        txn_t        mt;
        int          s_cnt = 0;
        int          rd_cnt = 0;
        int          wr_cnt = 0;
        logic [7:0]  last_rd = 8'h00;
`ifdef BUS_READY_EN
        logic        ready_;
        assign ready_ = !((!mr_ || !mw_) && strb_cnt >= W && strb_cnt < W + stall);
`endif

        bus_master_ctrl #(.WAIT_CYCLES(W)) dut (
            .clock  (clock),
            .reset  (rst),
            .req    (req),
            .we     (we),
            .addr   (addr),
            .wdata  (wdata),
`ifdef BUS_READY_EN
            .ready_ (ready_),
`endif
            .rdata  (rdata),
            .ack    (ack),
            .busy   (busy),
            .a23_a0 (a23_a0),
            .s_     (s_),
            .mr_    (mr_),
            .mw_    (mw_),
            .d7_d0  (d7_d0)
        );

        // Responder: data becomes valid only after the read strobe has been low W cycles.
        assign d7_d0 = (!mr_ && !s_) ? ((strb_cnt >= W) ? bus_mem[idx(a23_a0)] : 8'hEE) : 8'hzz;

        always @(posedge clock) begin
            if (!mr_ || !mw_) strb_cnt <= strb_cnt + 1;
            else              strb_cnt <= 0;
            if (!mw_ && !s_) bus_mem[idx(a23_a0)] <= d7_d0;
        end

        // Monitor
        always @(negedge clock) begin
            if (rst) begin
                s_cnt   = 0;
                rd_cnt  = 0;
                wr_cnt  = 0;
                last_rd = 8'h00;
            end else begin
                if (!s_ || !mr_ || !mw_) begin
                    check("strobe_excl", 32'(!mr_ && !mw_), 0);
                    check("strobe_without_sel", 32'((!mr_ || !mw_) && s_), 0);
                    check("sel_has_txn", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check("addr_stable", a23_a0, exp_q[0].addr);
                        if (exp_q[0].we) check("write_data_on_bus", d7_d0, exp_q[0].data);
                    end
                    if (!s_)  s_cnt++;
                    if (!mr_) rd_cnt++;
                    if (!mw_) wr_cnt++;
                end
                if (ack) begin
                    check("ack_has_txn", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        mt = exp_q.pop_front();
                        check("ack_cycle", cyc, mt.ack_cyc);
                        check("sel_width", s_cnt, W + 3 + mt.stall);
                        check("mr_width", rd_cnt, mt.we ? 0 : W + 1 + mt.stall);
                        check("mw_width", wr_cnt, mt.we ? W + 1 + mt.stall : 0);
                        check("sel_high_in_ack", s_, 1);
                        check("busy_in_ack", busy, 1);
                        if (!mt.we) last_rd = mt.data;
                        check("rdata", rdata, last_rd);
                    end
                    s_cnt  = 0;
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end

        task automatic launch(input logic t_we, input logic [23:0] t_addr, input logic [7:0] t_data,
                              input int t_stall, input int gap, output int unsigned e0);
            txn_t t;
            if (gap >= 0) begin
                req = 1'b0;
                repeat (gap) begin
                    @(posedge clock);
                    #1;
                end
            end
            we    = t_we;
            addr  = t_addr;
            wdata = t_data;
            stall = t_stall;
            req   = 1'b1;
            e0 = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
            t.we      = t_we;
            t.addr    = t_addr;
            t.data    = t_we ? t_data : ref_mem[idx(t_addr)];
            t.stall   = t_stall;
            t.ack_cyc = e0 + W + 3 + t_stall;
            exp_q.push_back(t);
            while (cyc < e0) begin
                @(posedge clock);
                #1;
            end
            we    = 1'($urandom_range(0, 1));
            addr  = 24'($urandom);
            wdata = 8'($urandom);
        endtask

        task automatic do_txn(input logic t_we, input logic [23:0] t_addr, input logic [7:0] t_data,
                              input int t_stall, input int gap);
            int unsigned e0;
            launch(t_we, t_addr, t_data, t_stall, gap, e0);
            for (int i = 0; i < 40 && !ack; i++) begin
                @(posedge clock);
                #1;
            end
            check("ack_seen", ack, 1);
            free_edge = cyc + 2;
            if (t_we) ref_mem[idx(t_addr)] = t_data;
        endtask

        task automatic do_abort(input logic [23:0] t_addr);
            int unsigned e0;
            launch(1'b0, t_addr, 8'h00, 0, 1, e0);
            while (cyc < e0 + 2) begin
                @(posedge clock);
                #1;
            end
            rst = 1'b1;
            req = 1'b0;
            void'(exp_q.pop_back());
            @(posedge clock);
            #1;
            check("abort_s_", s_, 1);
            check("abort_mr_", mr_, 1);
            check("abort_mw_", mw_, 1);
            check("abort_ack", ack, 0);
            check("abort_busy", busy, 0);
            check("abort_rdata", rdata, 8'h00);
            check("abort_addr", a23_a0, 24'h000000);
            rst = 1'b0;
            free_edge = cyc + 1;
        endtask

        initial begin
            logic [7:0] v;
            int         rdy_stall;
            int         t_stall;
            logic       t_we;
            rst   = 1'b1;
            req   = 1'b0;
            we    = 1'b0;
            addr  = 24'h0;
            wdata = 8'h0;
            for (int i = 0; i < 32; i++) begin
                v = 8'($urandom);
                bus_mem[i] <= v;
                ref_mem[i] = v;
            end
            bus_mem[16] <= 8'h00; ref_mem[16] = 8'h00;
            bus_mem[17] <= 8'h17; ref_mem[17] = 8'h17;
            bus_mem[18] <= 8'h41; ref_mem[18] = 8'h41;
            bus_mem[30] <= 8'h9E; ref_mem[30] = 8'h9E;
            repeat (3) @(posedge clock);
            #1;
            check("reset_s_", s_, 1);
            check("reset_mr_", mr_, 1);
            check("reset_mw_", mw_, 1);
            check("reset_ack", ack, 0);
            check("reset_busy", busy, 0);
            check("reset_rdata", rdata, 8'h00);
            check("reset_addr", a23_a0, 24'h000000);
            rst = 1'b0;
`ifdef BUS_READY_EN
            rdy_stall = 3;
`else
            rdy_stall = 0;
`endif
            do_txn(1'b0, 24'hFF0002, 8'h00, 0, 1);
            do_txn(1'b1, 24'h000010, 8'hA5, 0, 1);
            do_txn(1'b0, 24'h000010, 8'h00, 0, 0);
            do_txn(1'b0, 24'hFF0000, 8'h00, 0, 1);
            do_txn(1'b0, 24'hFF0001, 8'h00, 0, -1);
            do_abort(24'hFF0002);
            do_txn(1'b0, 24'hFF0001, 8'h00, 0, 1);
            do_txn(1'b0, 24'hFF000E, 8'h00, 0, 2);
            do_txn(1'b0, 24'hFF000E, 8'h00, rdy_stall, 1);
            for (int n = 0; n < 40; n++) begin
                t_we    = 1'($urandom_range(0, 1));
                t_stall = 0;
`ifdef BUS_READY_EN
                t_stall = $urandom_range(0, 3);
`endif
                do_txn(t_we, t_we ? (24'h000010 | 24'($urandom_range(0, 15)))
                                  : (($urandom_range(0, 1) != 0 ? 24'hFF0000 : 24'h000010)
                                     | 24'($urandom_range(0, 15))),
                       8'($urandom), t_stall, $urandom_range(0, 3) - 1);
            end
            req = 1'b0;
            repeat (4) @(posedge clock);
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        while (!(lane_done[0] && lane_done[1]) && cyc < 20000) @(posedge clock);
        check("lanes_done", {30'd0, lane_done[1], lane_done[0]}, 32'd3);
        check("queue_empty_w2", lane[0].exp_q.size(), 0);
        check("queue_empty_w0", lane[1].exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
